// File: rtl/axis_mul8_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_mul8_bridge_if
// Brief    : AXI-Stream beat bundle (tdata/tvalid/tlast/tready) with
//            master and slave views.
// Revision : 1.0
// ============================================================================
interface axis_mul8_bridge_if #(
    parameter int W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_mul8_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axis_mul8_bridge
// Brief    : AXI-Stream wrapper around a non-stallable pipelined multiplier,
//            with credit-based admission into a show-ahead result FIFO.
//            Optional counters enabled by AXIS_MUL8_STATS_EN.
// Revision : 1.0
// ============================================================================
module axis_mul8_bridge #(
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  wire                       clk,
    input  wire                       rst,
    axis_mul8_bridge_if.slave         s_axis,
    output logic                      mul_en,
    output logic [DATA_W-1:0]         mul_a,
    output logic [DATA_W-1:0]         mul_b,
    input  wire  [2*DATA_W-1:0]       mul_p,
    input  wire                       mul_valid,
    axis_mul8_bridge_if.master        m_axis,
    output logic                      err_ovf
`ifdef AXIS_MUL8_STATS_EN
    ,
    output logic [31:0]               stat_beats,
    output logic [31:0]               stat_pkts,
    output logic [31:0]               stat_stall
`endif
);

    localparam int c_PW = 2 * DATA_W;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_UW = c_AW + 1;
    localparam int c_GW = $clog2(MUL_LATENCY + 1);

    logic [c_GW-1:0]        r_guard_cnt;
    logic [c_UW-1:0]        r_used;
    logic [MUL_LATENCY-1:0] r_last_sr;
    logic [c_UW-1:0]        r_wr_ptr;
    logic [c_UW-1:0]        r_rd_ptr;
    logic [c_PW:0]          r_mem [FIFO_DEPTH];
    logic                   r_err_ovf;

    logic                   w_guard_done;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_cap;
    logic                   w_wr;
    logic                   w_full;
    logic                   w_empty;
    logic [c_PW:0]          w_head;

    // Admission depends only on registered state, so a downstream pop frees
    // a credit one cycle later rather than through a combinational path.
    assign w_guard_done  = (r_guard_cnt == c_GW'(MUL_LATENCY));
    assign s_axis.tready = w_guard_done && (r_used < c_UW'(FIFO_DEPTH));
    assign w_accept      = s_axis.tvalid && s_axis.tready;

    assign mul_en = w_accept;
    assign mul_a  = s_axis.tdata[c_PW-1:DATA_W];
    assign mul_b  = s_axis.tdata[DATA_W-1:0];

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = !w_empty && m_axis.tready;
    assign w_cap   = mul_valid && w_guard_done;
    assign w_wr    = w_cap && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign m_axis.tvalid = !w_empty;
    assign m_axis.tdata  = w_empty ? '0 : w_head[c_PW-1:0];
    assign m_axis.tlast  = !w_empty && w_head[c_PW];
    assign err_ovf       = r_err_ovf;

    // Guard window swallows whatever the multiplier flushes out of its own reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_guard_cnt <= '0;
        end else if (!w_guard_done) begin
            r_guard_cnt <= r_guard_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_used <= r_used + 1'b1;
                2'b01:   r_used <= r_used - 1'b1;
                default: r_used <= r_used;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_sr <= '0;
        end else begin
            r_last_sr[0] <= w_accept && s_axis.tlast;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_last_sr[i] <= r_last_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_cap && w_full && !w_pop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {r_last_sr[MUL_LATENCY-1], mul_p};
        end
    end

`ifdef AXIS_MUL8_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_beats <= '0;
            r_stat_pkts  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_pop) begin
                r_stat_beats <= r_stat_beats + 1'b1;
            end
            if (w_pop && m_axis.tlast) begin
                r_stat_pkts <= r_stat_pkts + 1'b1;
            end
            if (m_axis.tvalid && !m_axis.tready) begin
                r_stat_stall <= r_stat_stall + 1'b1;
            end
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_pkts  = r_stat_pkts;
    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_mul8_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_mul8_bridge
// Brief    : Directed bench for axis_mul8_bridge with a 3-stage multiplier model.
// Revision : 1.0
// ============================================================================
module tb_axis_mul8_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_en;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        mul_valid;
    logic        err_ovf;
`ifdef AXIS_MUL8_STATS_EN
    logic [31:0] stat_beats;
    logic [31:0] stat_pkts;
    logic [31:0] stat_stall;
`endif

    axis_mul8_bridge_if #(.W(16)) s_if ();
    axis_mul8_bridge_if #(.W(16)) m_if ();

    axis_mul8_bridge #(
        .DATA_W      (8),
        .MUL_LATENCY (3),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (s_if),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .mul_valid (mul_valid),
        .m_axis    (m_if),
        .err_ovf   (err_ovf)
`ifdef AXIS_MUL8_STATS_EN
        ,
        .stat_beats (stat_beats),
        .stat_pkts  (stat_pkts),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: three register stages, deliberately not reset so that
    // in-flight products survive a bridge reset.
    logic [15:0] r_p1 = '0, r_p2 = '0, r_p3 = '0;
    logic        r_v1 = 1'b0, r_v2 = 1'b0, r_v3 = 1'b0;
    always @(posedge clk) begin
        r_v1 <= mul_en;
        r_p1 <= {8'd0, mul_a} * {8'd0, mul_b};
        r_v2 <= r_v1;
        r_p2 <= r_p1;
        r_v3 <= r_v2;
        r_p3 <= r_p2;
    end
    assign mul_p     = r_p3;
    assign mul_valid = r_v3;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    int          n_last   = 0;
    int          cyc      = 0;
    logic [16:0] exp_q[$];
    int          pop_cyc[$];
    logic [16:0] r_mon_exp;

    int bp_a  [10] = '{1, 3, 5, 7, 9, 11, 13, 15, 17, 19};
    int bp_b  [10] = '{2, 4, 6, 8, 10, 12, 14, 16, 18, 20};
    int bp_exp[10] = '{2, 12, 30, 56, 90, 132, 182, 240, 306, 380};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                check("out_extra", {31'd0, m_if.tvalid}, 32'd0);
            end else begin
                r_mon_exp = exp_q.pop_front();
                check("out_data", {16'd0, m_if.tdata}, {16'd0, r_mon_exp[15:0]});
                check("out_last", {31'd0, m_if.tlast}, {31'd0, r_mon_exp[16]});
                pop_cyc.push_back(cyc);
                n_out++;
                if (m_if.tlast) n_last++;
            end
        end
    end

    // Presents one beat (called #2 after a rising edge); returns #2 after the
    // accepting edge, with the number of stalled cycles in waits.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last,
                        input logic [15:0] exp, output int waits);
        bit done = 1'b0;
        s_if.tdata  = {a, b};
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        waits = 0;
        while (!done) begin
            @(negedge clk);
            if (s_if.tready) begin
                exp_q.push_back({last, exp});
                n_acc++;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 300) begin
                    check("send_timeout", {31'd0, s_if.tready}, 32'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic guard_check(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(tag, {31'd0, s_if.tready}, {31'd0, (i == 3)});
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int w;
        rst         = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 16'h0102;
        s_if.tlast  = 1'b1;
        m_if.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
        check("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check("rst_m_tlast",  {31'd0, m_if.tlast},  32'd0);
        check("rst_m_tdata",  {16'd0, m_if.tdata},  32'd0);
        check("rst_err_ovf",  {31'd0, err_ovf},     32'd0);
        check("rst_mul_en",   {31'd0, mul_en},      32'd0);
        #1;
        idle();
        rst = 1'b0;
        guard_check("guard_start");

        // Single beat latency
        send(8'h03, 8'h05, 1'b1, 16'd15, w);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lat_tvalid", {31'd0, m_if.tvalid}, {31'd0, (i == 3)});
            if (i == 3) begin
                check("lat_tdata", {16'd0, m_if.tdata}, 32'd15);
                check("lat_tlast", {31'd0, m_if.tlast}, 32'd1);
            end
        end
        @(posedge clk);
        #2;

        // Extremes, back-to-back
        n_out = 0;
        pop_cyc.delete();
        send(8'd255, 8'd255, 1'b0, 16'd65025, w);
        check("b2b_accept0", w, 32'd0);
        send(8'd0, 8'd200, 1'b0, 16'd0, w);
        check("b2b_accept1", w, 32'd0);
        send(8'd128, 8'd2, 1'b1, 16'd256, w);
        check("b2b_accept2", w, 32'd0);
        idle();
        wait_drain();
        check("ext_count", n_out, 32'd3);
        if (pop_cyc.size() == 3) begin
            check("ext_tput0", pop_cyc[1] - pop_cyc[0], 32'd1);
            check("ext_tput1", pop_cyc[2] - pop_cyc[1], 32'd1);
        end

        // Backpressure, then release with input still pending
        n_out = 0;
        n_acc = 0;
        m_if.tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(bp_a[i][7:0], bp_b[i][7:0], (i == 9), bp_exp[i][15:0], w);
                end
                idle();
            end
            begin
                repeat (20) @(posedge clk);
                #2;
                check("bp_accepted", n_acc, 32'd8);
                check("bp_s_tready", {31'd0, s_if.tready}, 32'd0);
                check("bp_m_tvalid", {31'd0, m_if.tvalid}, 32'd1);
                check("bp_err_ovf",  {31'd0, err_ovf},     32'd0);
                m_if.tready = 1'b1;
                @(negedge clk);
                check("bp_no_comb_ready", {31'd0, s_if.tready}, 32'd0);
                @(negedge clk);
                check("bp_ready_after_pop", {31'd0, s_if.tready}, 32'd1);
            end
        join
        wait_drain();
        check("bp_count", n_out, 32'd10);
        check("bp_err_ovf_end", {31'd0, err_ovf}, 32'd0);

        // Packets of length 1, 4, 2
        n_out  = 0;
        n_last = 0;
        send(8'd2,   8'd3,   1'b1, 16'd6,     w);
        send(8'd4,   8'd5,   1'b0, 16'd20,    w);
        send(8'd6,   8'd7,   1'b0, 16'd42,    w);
        send(8'd8,   8'd9,   1'b0, 16'd72,    w);
        send(8'd10,  8'd11,  1'b1, 16'd110,   w);
        send(8'd20,  8'd30,  1'b0, 16'd600,   w);
        send(8'd100, 8'd100, 1'b1, 16'd10000, w);
        idle();
        wait_drain();
        check("pkt_count", n_out, 32'd7);
        check("pkt_lasts", n_last, 32'd3);

        // Reset with 3 beats in flight and 2 in the FIFO
        n_out = 0;
        m_if.tready = 1'b0;
        send(8'd21, 8'd2, 1'b0, 16'd42, w);
        send(8'd22, 8'd2, 1'b0, 16'd44, w);
        send(8'd23, 8'd2, 1'b0, 16'd46, w);
        send(8'd24, 8'd2, 1'b0, 16'd48, w);
        send(8'd25, 8'd2, 1'b1, 16'd50, w);
        idle();
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check("mid_rst_tdata",  {16'd0, m_if.tdata},  32'd0);
        check("mid_rst_tlast",  {31'd0, m_if.tlast},  32'd0);
        check("mid_rst_tready", {31'd0, s_if.tready}, 32'd0);
        exp_q.delete();
        m_if.tready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        guard_check("guard_mid");
        repeat (10) @(posedge clk);
        #2;
        check("mid_no_stale", n_out, 32'd0);
        check("mid_tvalid", {31'd0, m_if.tvalid}, 32'd0);

        send(8'd12, 8'd12, 1'b1, 16'd144, w);
        idle();
        wait_drain();
        check("post_rst_count", n_out, 32'd1);
        check("post_rst_err", {31'd0, err_ovf}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
